afpm_operand_driver: RTL and testbench

AFPM_OPERAND_DRIVER -- requirements
Module: afpm_operand_driver

---
 rtl/afpm_operand_driver.sv | 149 ++++++++++++++
 tb/tb_afpm_operand_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/afpm_operand_driver.sv
// Operand driver for a byte-serial fp16 multiplier: streams A/B low byte then high byte,
// waits WAIT_CYC cycles, captures the two result bytes and holds them until accepted.
module afpm_operand_driver #(
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    input  logic [7:0]  res_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy,
    output logic [7:0]  txn_count
);

    typedef enum logic [2:0] {
        StIdle,
        StSendLo,
        StSendHi,
        StWait,
        StCapLo,
        StCapHi,
        StDone
    } state_e;

    localparam bit          NoWait   = (WAIT_CYC == 32'd0);
    localparam int unsigned WaitM1   = NoWait ? 32'd0 : WAIT_CYC - 32'd1;
    localparam logic [3:0]  WaitLoad = WaitM1[3:0];

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [15:0] res_q, res_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic [7:0]  txn_q, txn_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        txn_d   = txn_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = StSendLo;
                end
            end
            StSendLo: state_d = StSendHi;
            StSendHi: begin
                if (NoWait) begin
                    state_d = StCapLo;
                end else begin
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                end
            end
            StWait: begin
                // Counter holds the remaining WAIT cycles after the current one.
                if (cnt_q == 4'd0) begin
                    state_d = StCapLo;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapLo: begin
                res_d[7:0] = res_in;
                state_d    = StCapHi;
            end
            StCapHi: begin
                res_d[15:8] = res_in;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    txn_d   = txn_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        op_a_d = 8'h00;
        op_b_d = 8'h00;
        if (state_d == StSendLo) begin
            op_a_d = a_d[7:0];
            op_b_d = b_d[7:0];
        end else if (state_d == StSendHi) begin
            op_a_d = a_d[15:8];
            op_b_d = b_d[15:8];
        end
        out_valid_d = (state_d == StDone);
        in_ready_d  = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            cnt_q       <= 4'd0;
            op_a_q      <= 8'h00;
            op_b_q      <= 8'h00;
            res_q       <= 16'h0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            txn_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            txn_q       <= txn_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign busy      = busy_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_afpm_operand_driver.sv
// Randomized scoreboard bench for afpm_operand_driver (WAIT_CYC=2) plus a directed
// check of a WAIT_CYC=0 instance.
module tb_afpm_operand_driver;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [15:0] a_in, b_in;
    logic [7:0]  op_a, op_b, res_in;
    logic        out_valid, out_ready;
    logic [15:0] result;
    logic        busy;
    logic [7:0]  txn_count;

    logic        iv0, ir0, ov0, ordy0, busy0;
    logic [15:0] a0, b0, result0;
    logic [7:0]  oa0, ob0, res0, tc0;

    always #5 clk = ~clk;

    afpm_operand_driver #(.WAIT_CYC(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .op_a(op_a), .op_b(op_b), .res_in(res_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy),
        .txn_count(txn_count)
    );

    afpm_operand_driver #(.WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a_in(a0), .b_in(b0), .op_a(oa0), .op_b(ob0), .res_in(res0),
        .out_valid(ov0), .out_ready(ordy0), .result(result0), .busy(busy0),
        .txn_count(tc0)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        int          acc;
        int          hold;
    } txn_t;

    txn_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Monitor: behavioural model of one transaction at a time, indexed by cycles since accept.
    txn_t        cur;
    bit          mon_act = 1'b0;
    int          obs_busy = 0;
    int          mk;
    logic [7:0]  exp_txn = 8'h00;
    logic [15:0] last_r = 16'h0000;
    logic [7:0]  ea, eb;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                sb.delete();
                mon_act = 1'b0;
                exp_txn = 8'h00;
                last_r  = 16'h0000;
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_result", result, 0);
                chk("rst_txn_count", txn_count, 0);
            end else begin
                if (mon_act && (cyc - 1 - cur.acc) >= 4 + W && out_ready) begin
                    mon_act = 1'b0;
                    exp_txn++;
                    last_r = cur.r;
                    chk("busy_span", obs_busy, 5 + W + cur.hold);
                end
                if (!mon_act && sb.size() > 0) begin
                    if (sb[0].acc == cyc) begin
                        cur      = sb.pop_front();
                        mon_act  = 1'b1;
                        obs_busy = 0;
                    end else if (sb[0].acc < cyc) begin
                        chk("accept_lost", cyc, sb[0].acc);
                        void'(sb.pop_front());
                    end
                end
                if (mon_act) begin
                    mk = cyc - cur.acc;
                    ea = (mk == 0) ? cur.a[7:0] : (mk == 1) ? cur.a[15:8] : 8'h00;
                    eb = (mk == 0) ? cur.b[7:0] : (mk == 1) ? cur.b[15:8] : 8'h00;
                    chk("op_a", op_a, ea);
                    chk("op_b", op_b, eb);
                    chk("in_ready_busy", in_ready, 0);
                    chk("busy", busy, 1);
                    chk("out_valid", out_valid, mk >= 4 + W);
                    if (mk <= 2 + W) chk("result_retained", result, last_r);
                    else if (mk == 3 + W) chk("result_lo", result, {last_r[15:8], cur.r[7:0]});
                    else chk("result", result, cur.r);
                    chk("txn_count", txn_count, exp_txn);
                    if (busy) obs_busy++;
                end else begin
                    chk("idle_in_ready", in_ready, 1);
                    chk("idle_busy", busy, 0);
                    chk("idle_out_valid", out_valid, 0);
                    chk("idle_op_a", op_a, 0);
                    chk("idle_op_b", op_b, 0);
                    chk("idle_result", result, last_r);
                    chk("idle_txn_count", txn_count, exp_txn);
                end
            end
        end
    end

    // Drives one transaction; returns at the negedge of the first IDLE cycle afterwards.
    task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                          input int hold, input bit junk, input bit rst_mid);
        int   n;
        int   acc;
        int   k;
        txn_t t;
        n = 0;
        while (in_ready !== 1'b1) begin
            in_valid = 1'b0;
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("ready_timeout", in_ready, 1);
                return;
            end
        end
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        res_in    = 8'($urandom);
        out_ready = 1'($urandom);
        acc       = cyc + 1;
        t.a = a; t.b = b; t.r = r; t.acc = acc; t.hold = hold;
        sb.push_back(t);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            k        = cyc - acc;
            in_valid = junk ? 1'($urandom) : 1'b0;
            a_in     = 16'($urandom);
            b_in     = 16'($urandom);
            res_in   = (k == 2 + W) ? r[7:0] : (k == 3 + W) ? r[15:8] : 8'($urandom);
            if (rst_mid && k == 3) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_out_valid", out_valid, 0);
                chk("async_rst_in_ready", in_ready, 1);
                chk("async_rst_busy", busy, 0);
                chk("async_rst_op", {op_a, op_b}, 0);
                chk("async_rst_result", result, 0);
                chk("async_rst_txn_count", txn_count, 0);
                @(negedge clk);
                rst_n    = 1'b1;
                in_valid = 1'b0;
                return;
            end
            if (k >= 4 + W) begin
                out_ready = (k - (4 + W)) >= hold;
                if (out_ready) break;
            end else begin
                out_ready = 1'($urandom);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'($urandom);
    endtask

    int acc0;

    initial begin
        in_valid = 1'b0; a_in = '0; b_in = '0; res_in = '0; out_ready = 1'b0;
        iv0 = 1'b0; a0 = '0; b0 = '0; res0 = '0; ordy0 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_txn(16'h3E00, 16'h4200, 16'h4480, 5, 1'b1, 1'b0);
        repeat (20) do_txn(16'($urandom), 16'($urandom), 16'($urandom),
                           int'($urandom_range(0, 3)), 1'b1, 1'b0);
        do_txn(16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            do_txn(16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
        end
        chk("txn_wrap", txn_count, 8'h00);

        // Zero-wait instance: SEND_HI must be followed directly by CAP_LO.
        @(negedge clk);
        iv0 = 1'b1; a0 = 16'h0101; b0 = 16'h0101; ordy0 = 1'b1;
        acc0 = cyc + 1;
        chk("w0_in_ready", ir0, 1);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("w0_phase", cyc - acc0, k);
            iv0  = 1'b0;
            res0 = (k == 2) ? 8'hAD : (k == 3) ? 8'hDE : 8'h00;
            chk("w0_op_a", oa0, (k < 2) ? 8'h01 : 8'h00);
            chk("w0_op_b", ob0, (k < 2) ? 8'h01 : 8'h00);
            chk("w0_out_valid", ov0, k == 4);
            chk("w0_busy", busy0, k < 5);
            if (k == 3) chk("w0_res_lo", result0[7:0], 8'hAD);
            if (k >= 4) chk("w0_result", result0, 16'hDEAD);
            if (k == 5) chk("w0_txn_count", tc0, 1);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
